// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 16-bit SRAM port between the CPU
// (load/store) and the video scanout fetcher, one access per clk_core cycle.
// Video has fixed priority; a saturating wait counter lets a CPU request that
// has been refused CPU_MAX_WAIT consecutive cycles win over video.
//
// Optional build macro: SRAM_ARB_TURNAROUND_EN
//   Defined:   the cycle in which a CPU write is on the pads (sram_wr=1) may
//              not grant a read; a CPU write may still be granted there.
//   Undefined: a read may follow a write immediately.
//
// Handshake: a requester holds *_req (and its address/data) high; *_gnt is
// combinational and means the request is consumed at the coming clk_core
// edge. Read data comes back as a one-cycle *_rvalid pulse two cycles after
// the grant, with no back-pressure.
module sram_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 16,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic          clk_core,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  output logic [AW-1:0] sram_a,
  output logic          sram_wr,
  output logic [DW-1:0] host_to_sram,
  input  logic [DW-1:0] sram_to_host
);

  // Four bits cover the whole legal CPU_MAX_WAIT range of 1..15.
  localparam int            WCW  = 4;
  localparam logic [WCW-1:0] MAXW = WCW'(CPU_MAX_WAIT);

  // Tag carried by each issued access so read data is routed to its owner.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_e;

  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0]  sram_a_q, sram_a_d;
  logic           sram_wr_q, sram_wr_d;
  logic [DW-1:0]  host_to_sram_q, host_to_sram_d;
  owner_e         own_q, own_d;
  logic           cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic           vid_rvalid_q, vid_rvalid_d;
  logic [DW-1:0]  vid_rdata_q, vid_rdata_d;

  logic block_rd;
  logic cpu_ok;
  logic vid_ok;

  // The turnaround flag is the registered write strobe itself: it is high
  // exactly in the cycle a CPU write is being driven onto the pads.
`ifdef SRAM_ARB_TURNAROUND_EN
  assign block_rd = sram_wr_q;
`else
  assign block_rd = 1'b0;
`endif

  // Arbitration: starved CPU first, then video, then CPU; no grants in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    cpu_ok  = cpu_req & (cpu_wr | ~block_rd);
    vid_ok  = vid_req & ~block_rd;
    if (!reset) begin
      if (cpu_ok && (wait_cnt_q == MAXW)) begin
        cpu_gnt = 1'b1;
      end else if (vid_ok) begin
        vid_gnt = 1'b1;
      end else if (cpu_ok) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  // Next-state: wait counter, SRAM issue registers, owner tag, read return.
  always_comb begin
    wait_cnt_d     = wait_cnt_q;
    sram_a_d       = sram_a_q;
    sram_wr_d      = 1'b0;
    host_to_sram_d = host_to_sram_q;
    own_d          = OWN_NONE;
    cpu_rvalid_d   = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    vid_rvalid_d   = 1'b0;
    vid_rdata_d    = vid_rdata_q;

    // Counts consecutive refusals of a pending CPU request, saturating.
    if (!cpu_req || cpu_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAXW) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Issue stage: address and strobe go to the pads next cycle.
    if (cpu_gnt) begin
      sram_a_d  = cpu_addr;
      sram_wr_d = cpu_wr;
      if (cpu_wr) begin
        host_to_sram_d = cpu_wdata;
      end else begin
        own_d = OWN_CPU;
      end
    end else if (vid_gnt) begin
      sram_a_d = vid_addr;
      own_d    = OWN_VID;
    end

    // Return stage: the access on the pads this cycle is sampled at its end.
    if (own_q == OWN_CPU) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = sram_to_host;
    end
    if (own_q == OWN_VID) begin
      vid_rvalid_d = 1'b1;
      vid_rdata_d  = sram_to_host;
    end
  end

  // State registers with synchronous reset; reset drops any read in flight.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      wait_cnt_q     <= '0;
      sram_a_q       <= '0;
      sram_wr_q      <= 1'b0;
      host_to_sram_q <= '0;
      own_q          <= OWN_NONE;
      cpu_rvalid_q   <= 1'b0;
      cpu_rdata_q    <= '0;
      vid_rvalid_q   <= 1'b0;
      vid_rdata_q    <= '0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      sram_a_q       <= sram_a_d;
      sram_wr_q      <= sram_wr_d;
      host_to_sram_q <= host_to_sram_d;
      own_q          <= own_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
      cpu_rdata_q    <= cpu_rdata_d;
      vid_rvalid_q   <= vid_rvalid_d;
      vid_rdata_q    <= vid_rdata_d;
    end
  end

  assign sram_a       = sram_a_q;
  assign sram_wr      = sram_wr_q;
  assign host_to_sram = host_to_sram_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign vid_rvalid   = vid_rvalid_q;
  assign vid_rdata    = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: drives sram_arbiter with directed and random traffic
// against an asynchronous SRAM model, predicts grants and returned data from
// the arbitration rules and a reference memory, and scoreboards the pad
// outputs and both read-return channels cycle by cycle.
module tb_sram_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int MAXW = 4;
`ifdef SRAM_ARB_TURNAROUND_EN
  localparam bit TURN = 1'b1;
`else
  localparam bit TURN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_core = 1'b0;
  logic reset;
  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  logic          cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          vid_req, vid_gnt, vid_rvalid;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic [AW-1:0] sram_a;
  logic          sram_wr;
  logic [DW-1:0] host_to_sram, sram_to_host;

  sram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(MAXW)) dut (
    .clk_core(clk_core), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .sram_a(sram_a), .sram_wr(sram_wr), .host_to_sram(host_to_sram),
    .sram_to_host(sram_to_host)
  );

  // Asynchronous SRAM: reads follow the address, writes land at cycle end.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk_core) if (sram_wr === 1'b1) mem[sram_a] <= host_to_sram;
  assign sram_to_host = mem[sram_a];

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_wait;
  bit            m_wr_now;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] last_cpu_rd, last_vid_rd;

  typedef struct { logic [DW-1:0] data; int due; } rsp_t;
  typedef struct { logic [AW-1:0] a; logic wr; logic [DW-1:0] wd; int due; } iss_t;
  rsp_t cpu_q[$];
  rsp_t vid_q[$];
  iss_t iss_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic c_req, input logic c_wr,
                      input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                      input logic v_req, input logic [AW-1:0] v_addr,
                      output logic c_got);
    bit blk, c_ok, v_ok, exp_c, exp_v;
    @(negedge clk_core);
    reset = rst; cpu_req = c_req; cpu_wr = c_wr; cpu_addr = c_addr;
    cpu_wdata = c_wd; vid_req = v_req; vid_addr = v_addr;
    #1;
    exp_c = 1'b0; exp_v = 1'b0;
    if (!rst) begin
      blk  = TURN && m_wr_now;
      c_ok = c_req && (c_wr || !blk);
      v_ok = v_req && !blk;
      if (c_ok && m_wait == MAXW) exp_c = 1'b1;
      else if (v_ok)              exp_v = 1'b1;
      else if (c_ok)              exp_c = 1'b1;
    end
    check("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, exp_c});
    check("vid_gnt", {31'd0, vid_gnt}, {31'd0, exp_v});
    if (rst) begin
      m_wait = 0; m_wr_now = 1'b0; m_a = '0; m_wd = '0;
      last_cpu_rd = '0; last_vid_rd = '0;
      cpu_q.delete(); vid_q.delete(); iss_q.delete();
      iss_q.push_back('{a: '0, wr: 1'b0, wd: '0, due: cyc + 1});
    end else begin
      if (!c_req || exp_c) m_wait = 0;
      else if (m_wait < MAXW) m_wait = m_wait + 1;
      if (exp_c) begin
        m_a = c_addr;
        if (c_wr) begin
          m_wd = c_wd;
          ref_mem[c_addr] = c_wd;
        end else begin
          cpu_q.push_back('{data: ref_mem[c_addr], due: cyc + 2});
        end
      end else if (exp_v) begin
        m_a = v_addr;
        vid_q.push_back('{data: ref_mem[v_addr], due: cyc + 2});
      end
      m_wr_now = exp_c && c_wr;
      iss_q.push_back('{a: m_a, wr: m_wr_now, wd: m_wd, due: cyc + 1});
    end
    c_got = exp_c;
  endtask

  task automatic idle(input int n);
    logic g;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, g);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_core) begin
    if (mon_en) begin
      while (iss_q.size() > 0 && iss_q[0].due < cyc) begin
        check("issue_missed", 32'(iss_q[0].due), 32'(cyc));
        void'(iss_q.pop_front());
      end
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        check("sram_a", 32'(sram_a), 32'(iss_q[0].a));
        check("sram_wr", {31'd0, sram_wr}, {31'd0, iss_q[0].wr});
        check("host_to_sram", 32'(host_to_sram), 32'(iss_q[0].wd));
        void'(iss_q.pop_front());
      end
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        check("cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q[0].data));
        last_cpu_rd = cpu_q[0].data;
        void'(cpu_q.pop_front());
      end else begin
        check("cpu_rvalid_idle", {31'd0, cpu_rvalid}, 32'd0);
        check("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_cpu_rd));
      end
      if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
        check("vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
        check("vid_rdata", 32'(vid_rdata), 32'(vid_q[0].data));
        last_vid_rd = vid_q[0].data;
        void'(vid_q.pop_front());
      end else begin
        check("vid_rvalid_idle", {31'd0, vid_rvalid}, 32'd0);
        check("vid_rdata_hold", 32'(vid_rdata), 32'(last_vid_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic          g;
    logic [AW-1:0] va;
    bit            pend;
    logic          p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    int            n;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[14'h0123]     = 16'hBEEF;
    ref_mem[14'h0123] = 16'hBEEF;
    m_wait = 0; m_wr_now = 1'b0; m_a = '0; m_wd = '0;
    last_cpu_rd = '0; last_vid_rd = '0;

    // Reset with both requesters asking: no grants, all outputs cleared.
    reset = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0055;
    cpu_wdata = 16'h1234; vid_req = 1'b1; vid_addr = 14'h0066;
    repeat (3) @(negedge clk_core);
    check("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("rst_vid_gnt", {31'd0, vid_gnt}, 32'd0);
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_sram_wr", {31'd0, sram_wr}, 32'd0);
    check("rst_host_to_sram", 32'(host_to_sram), 32'd0);
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_vid_rdata", 32'(vid_rdata), 32'd0);
    mon_en = 1'b1;
    idle(1);

    // CPU-only read of a known word, then CPU write at the top address.
    step(1'b0, 1'b1, 1'b0, 14'h0123, '0, 1'b0, '0, g);
    idle(3);
    step(1'b0, 1'b1, 1'b1, 14'h3FFF, 16'hA5A5, 1'b0, '0, g);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 14'h3FFF, '0, 1'b0, '0, g);
    idle(3);

    // Contention: video streams, CPU must win within MAXW+1 cycles.
    va = 14'h0100;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 14'h0040, '0, 1'b1, va, g);
      va = va + 1'b1;
      n = i;
      if (cpu_gnt === 1'b1) break;
    end
    check("starve_bound", 32'(n), 32'(MAXW + 1));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 14'h0041, '0, 1'b1, va, g);
      va = va + 1'b1;
    end
    idle(3);

    // Back-to-back reads alternating between requesters.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, AW'(14'h0200 + i), g);
      else            step(1'b0, 1'b1, 1'b0, AW'(14'h0300 + i), '0, 1'b0, '0, g);
    end
    idle(3);

    // Reset the cycle after a video grant: its data must never appear.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 14'h0010, g);
    step(1'b1, 1'b1, 1'b0, 14'h0011, '0, 1'b1, 14'h0012, g);
    idle(4);

    // Write followed by a waiting video read: bubble only with turnaround.
    step(1'b0, 1'b1, 1'b1, 14'h0020, 16'h5A5A, 1'b0, '0, g);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 14'h0020, g);
    check("turn_first_vid_gnt", {31'd0, vid_gnt}, {31'd0, !TURN});
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 14'h0020, g);
    check("turn_second_vid_gnt", {31'd0, vid_gnt}, 32'd1);
    idle(3);

    // Random traffic on a small address window so writes and reads collide.
    pend = 1'b0; p_wr = 1'b0; p_addr = '0; p_wd = '0;
    for (int i = 0; i < 3000; i++) begin
      logic rst_now;
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend   = 1'b1;
        p_wr   = ($urandom_range(0, 2) == 0);
        p_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
        p_wd   = DW'($urandom);
      end
      rst_now = ($urandom_range(0, 299) == 0);
      step(rst_now, pend, p_wr, p_addr, p_wd, ($urandom_range(0, 2) != 0),
           AW'($urandom_range(0, 31)), g);
      if (g) pend = 1'b0;
    end
    idle(4);

    check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    check("vid_queue_drained", 32'(vid_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
